cpu_seq_ctrl: RTL and testbench
===============================

Name: cpu_seq_ctrl

Overview:
Multi-cycle sequencer for the HW2 CPU core. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and issues every datapath strobe. Strobes include the PC register write enable, PC source select, instruction-register load, memory requests and register-file write. It also owns memory-wait watchdogs, a retired-instruction counter and the finish/status report to the testbench.

Parameters:
CNT_WIDTH, 16, width of retired-instruction counter o_retire_cnt
TIMEOUT_CYC, 64, max cycles a memory request may wait for valid before timeout error (>=1)
TO_WIDTH, 7, width of internal wait counter; must hold TIMEOUT_CYC

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  one-cycle pulse, begins execution from IDLE
i_imem_valid  input  1  instruction memory data valid for current request
i_dmem_valid  input  1  data memory read data valid / write accepted
i_dec_illegal  input  1  decoder: unsupported opcode (valid in DECODE)
i_dec_halt  input  1  decoder: end-of-program instruction (valid in DECODE)
i_dec_load  input  1  decoder: load (valid in DECODE)
i_dec_store  input  1  decoder: store (valid in DECODE)
i_dec_rd_we  input  1  decoder: instruction writes rd (valid in DECODE)
i_br_taken  input  1  branch/jump redirect from ALU (valid in EXEC)
o_pc_en  output  1  write enable to PC register
o_pc_sel  output  1  0: PC+4, 1: branch/jump target
o_imem_req  output  1  instruction fetch request
o_ir_en  output  1  instruction register load
o_dmem_req  output  1  data memory request
o_dmem_we  output  1  1: store, 0: load (meaningful only with o_dmem_req)
o_rf_we  output  1  register-file write enable
o_done  output  1  program finished (halt or error), sticky
o_status  output  2  00 running/idle, 01 normal halt, 10 illegal instr, 11 memory timeout
o_retire_cnt  output  CNT_WIDTH  instructions completed

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; retire counter 0; wait counter 0; latched decode flags 0. Requests drop immediately on reset assertion, not at the next edge.
- All outputs are Moore-style decodes of registered state and latched flags, except o_ir_en. o_ir_en = (state==FETCH && i_imem_valid).
- IDLE: outputs 0; on i_start go to FETCH next cycle. i_start is ignored in all other states.
- FETCH: o_imem_req=1 held until i_imem_valid.
  - Valid cycle: o_ir_en=1; next state DECODE.
  - Each non-valid cycle increments the wait counter.
  - Wait counter reaching TIMEOUT_CYC without valid -> TERR.
  - Valid in the same cycle the counter reaches TIMEOUT_CYC: valid wins.
  - Wait counter clears on leaving FETCH or MEM.
- DECODE (1 cycle): latch load/store/rd_we.
  - Priority: illegal -> IERR; else halt -> HALT; else EXEC.
- EXEC (1 cycle): latch i_br_taken. Next state MEM if load or store, else WB.
- MEM: o_dmem_req=1 and o_dmem_we=latched store, held until i_dmem_valid. Same timeout rule as FETCH. Then WB.
- WB (1 cycle), then FETCH:
  - o_rf_we=latched rd_we.
  - o_pc_en=1; o_pc_sel=latched br_taken.
  - retire counter +1, saturating at all-ones.
- o_pc_en is asserted only in WB, so PC holds during all waits. Exactly one PC update per retired instruction.
- Halt and error instructions do not update PC, RF or the counter.
- HALT: o_done=1, o_status=01. IERR: o_done=1, o_status=10. TERR: o_done=1, o_status=11.
  - All three are terminal until reset. All strobes stay 0 in these states.
- Minimum instruction latency with zero-wait memory: 4 cycles for non-memory (FETCH, DECODE, EXEC, WB); 5 for load/store.

Test Plan:
- Reset mid-MEM wait (o_dmem_req=1) -> o_dmem_req falls combinationally with i_rst_n; after release, state IDLE, o_retire_cnt=0, all outputs 0.
- i_start, 3 ALU instrs (rd_we=1), zero-wait imem, then halt -> o_pc_en pulses exactly 3 times, 4 cycles apart, o_pc_sel=0; o_rf_we=3 pulses; o_retire_cnt=3; o_done=1, o_status=01; PC enable never asserts for halt.
- Load with dmem valid after 5 cycles, then store with 0-wait -> o_dmem_req held 6 cycles with o_dmem_we=0; then 1 cycle with o_dmem_we=1; o_rf_we only for load (rd_we=1); o_retire_cnt=2.
- Taken branch (i_br_taken=1 in EXEC, rd_we=0) -> WB has o_pc_en=1, o_pc_sel=1, o_rf_we=0.
- imem never valid -> o_imem_req high exactly TIMEOUT_CYC=64 cycles, then o_done=1, o_status=11. Variant: valid on the 64th cycle -> DECODE proceeds, no error.
- i_dec_illegal and i_dec_halt both 1 in DECODE -> o_status=10, o_pc_en never asserted; a further i_start pulse is ignored.

Source files
------------

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle instruction sequencer: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives datapath strobes, watches memory waits.
module cpu_seq_ctrl #(
    parameter int CNT_WIDTH   = 16,
    parameter int TIMEOUT_CYC = 64,
    parameter int TO_WIDTH    = 7
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_imem_valid,
    input  logic                 i_dmem_valid,
    input  logic                 i_dec_illegal,
    input  logic                 i_dec_halt,
    input  logic                 i_dec_load,
    input  logic                 i_dec_store,
    input  logic                 i_dec_rd_we,
    input  logic                 i_br_taken,
    output logic                 o_pc_en,
    output logic                 o_pc_sel,
    output logic                 o_imem_req,
    output logic                 o_ir_en,
    output logic                 o_dmem_req,
    output logic                 o_dmem_we,
    output logic                 o_rf_we,
    output logic                 o_done,
    output logic [1:0]           o_status,
    output logic [CNT_WIDTH-1:0] o_retire_cnt
);

    // state    | meaning
    // ---------+-----------------------------------------------
    // S_IDLE   | waiting for i_start
    // S_FETCH  | instruction request outstanding
    // S_DECODE | latch decoder flags, catch halt/illegal
    // S_EXEC   | latch branch decision
    // S_MEM    | data request outstanding (load or store)
    // S_WB     | PC update, RF write, retire
    // S_HALT   | normal end of program (terminal)
    // S_IERR   | illegal instruction (terminal)
    // S_TERR   | memory wait timeout (terminal)
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_IERR, S_TERR
    } state_t;

    localparam logic [TO_WIDTH-1:0] WAIT_LAST = TO_WIDTH'(TIMEOUT_CYC - 1);

    state_t                state;
    logic [TO_WIDTH-1:0]   wait_cnt;
    logic                  lat_load;
    logic                  lat_store;
    logic                  lat_rd_we;
    logic                  lat_br;
    logic [CNT_WIDTH-1:0]  retire_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            lat_load   <= 1'b0;
            lat_store  <= 1'b0;
            lat_rd_we  <= 1'b0;
            lat_br     <= 1'b0;
            retire_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) state <= S_FETCH;
                end
                S_FETCH: begin
                    // valid on the final allowed wait cycle still wins
                    if (i_imem_valid) begin
                        state    <= S_DECODE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state    <= S_TERR;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + TO_WIDTH'(1);
                    end
                end
                S_DECODE: begin
                    lat_load  <= i_dec_load;
                    lat_store <= i_dec_store;
                    lat_rd_we <= i_dec_rd_we;
                    if (i_dec_illegal)   state <= S_IERR;
                    else if (i_dec_halt) state <= S_HALT;
                    else                 state <= S_EXEC;
                end
                S_EXEC: begin
                    lat_br <= i_br_taken;
                    state  <= (lat_load || lat_store) ? S_MEM : S_WB;
                end
                S_MEM: begin
                    if (i_dmem_valid) begin
                        state    <= S_WB;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state    <= S_TERR;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + TO_WIDTH'(1);
                    end
                end
                S_WB: begin
                    if (retire_cnt != '1) retire_cnt <= retire_cnt + CNT_WIDTH'(1);
                    state <= S_FETCH;
                end
                default: state <= state;
            endcase
        end
    end

    // Decoded straight from state so requests drop the moment reset asserts.
    assign o_imem_req   = (state == S_FETCH);
    assign o_ir_en      = (state == S_FETCH) && i_imem_valid;
    assign o_dmem_req   = (state == S_MEM);
    assign o_dmem_we    = (state == S_MEM) && lat_store;
    assign o_pc_en      = (state == S_WB);
    assign o_pc_sel     = (state == S_WB) && lat_br;
    assign o_rf_we      = (state == S_WB) && lat_rd_we;
    assign o_done       = (state == S_HALT) || (state == S_IERR) || (state == S_TERR);
    assign o_retire_cnt = retire_cnt;

    always_comb begin
        o_status = 2'b00;
        case (state)
            S_HALT:  o_status = 2'b01;
            S_IERR:  o_status = 2'b10;
            S_TERR:  o_status = 2'b11;
            default: o_status = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Random programs expanded into an expected per-cycle trace of inputs and
// outputs, replayed against cpu_seq_ctrl; includes async resets mid-run.
module tb_cpu_seq_ctrl;

    localparam int TOUT = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start, imem_valid, dmem_valid, dec_illegal, dec_halt;
    logic        dec_load, dec_store, dec_rd_we, br_taken;
    logic        pc_en, pc_sel, imem_req, ir_en, dmem_req, dmem_we, rf_we, done;
    logic [1:0]  status;
    logic [15:0] retire_cnt;

    cpu_seq_ctrl #(.CNT_WIDTH(16), .TIMEOUT_CYC(TOUT), .TO_WIDTH(7)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .i_imem_valid(imem_valid), .i_dmem_valid(dmem_valid),
        .i_dec_illegal(dec_illegal), .i_dec_halt(dec_halt),
        .i_dec_load(dec_load), .i_dec_store(dec_store),
        .i_dec_rd_we(dec_rd_we), .i_br_taken(br_taken),
        .o_pc_en(pc_en), .o_pc_sel(pc_sel), .o_imem_req(imem_req),
        .o_ir_en(ir_en), .o_dmem_req(dmem_req), .o_dmem_we(dmem_we),
        .o_rf_we(rf_we), .o_done(done), .o_status(status),
        .o_retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic start, iv, dv, ill, hlt, ld, st, rdwe, br;
        logic [25:0] exp;
    } cyc_t;

    cyc_t        tr[$];
    logic [15:0] mcnt;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [25:0] got, input logic [25:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // observed outputs in the same packing as the model; store flag only counts with a request
    function automatic logic [25:0] obs();
        return {pc_en, pc_sel, imem_req, ir_en, dmem_req, dmem_we & dmem_req,
                rf_we, done, status, retire_cnt};
    endfunction

    function automatic logic [25:0] ex(input logic pe, ps, ireq, ir, dreq, dwe, rf, dn,
                                        input logic [1:0] st, input logic [15:0] cnt);
        return {pe, ps, ireq, ir, dreq, dwe, rf, dn, st, cnt};
    endfunction

    function automatic cyc_t rin();
        cyc_t c;
        c.start = 1'($urandom); c.iv = 1'($urandom); c.dv = 1'($urandom);
        c.ill = 1'($urandom); c.hlt = 1'($urandom); c.ld = 1'($urandom);
        c.st = 1'($urandom); c.rdwe = 1'($urandom); c.br = 1'($urandom);
        c.exp = '0;
        return c;
    endfunction

    function automatic int pick_wait();
        int r;
        r = int'($urandom % 12);
        if (r == 0) return TOUT - 1;
        if (r < 5) return 0;
        return 1 + int'($urandom % 6);
    endfunction

    task automatic do_fetch(input int w, input bit ok);
        cyc_t c;
        for (int j = 0; j < w; j++) begin
            c = rin(); c.iv = 1'b0;
            c.exp = ex(0, 0, 1, 0, 0, 0, 0, 0, 2'b00, mcnt);
            tr.push_back(c);
        end
        if (ok) begin
            c = rin(); c.iv = 1'b1;
            c.exp = ex(0, 0, 1, 1, 0, 0, 0, 0, 2'b00, mcnt);
            tr.push_back(c);
        end
    endtask

    task automatic do_term(input logic [1:0] st);
        cyc_t c;
        repeat (3 + int'($urandom % 3)) begin
            c = rin();
            c.exp = ex(0, 0, 0, 0, 0, 0, 0, 1, st, mcnt);
            tr.push_back(c);
        end
    endtask

    task automatic do_instr();
        cyc_t c;
        logic ld, st, rdwe, br;
        int   d;
        ld = 1'($urandom); st = 1'($urandom); rdwe = 1'($urandom); br = 1'($urandom);
        do_fetch(pick_wait(), 1'b1);
        c = rin(); c.ill = 1'b0; c.hlt = 1'b0; c.ld = ld; c.st = st; c.rdwe = rdwe;
        c.exp = ex(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, mcnt);
        tr.push_back(c);
        c = rin(); c.br = br;
        c.exp = ex(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, mcnt);
        tr.push_back(c);
        if (ld || st) begin
            d = pick_wait();
            for (int j = 0; j <= d; j++) begin
                c = rin(); c.dv = (j == d);
                c.exp = ex(0, 0, 0, 0, 1, st, 0, 0, 2'b00, mcnt);
                tr.push_back(c);
            end
        end
        c = rin();
        c.exp = ex(1, br, 0, 0, 0, 0, rdwe, 0, 2'b00, mcnt);
        tr.push_back(c);
        mcnt++;
    endtask

    task automatic build();
        cyc_t c;
        int   kind;
        mcnt = '0;
        repeat (int'($urandom % 3)) begin
            c = rin(); c.start = 1'b0;
            c.exp = ex(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, mcnt);
            tr.push_back(c);
        end
        c = rin(); c.start = 1'b1;
        c.exp = ex(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, mcnt);
        tr.push_back(c);
        repeat (1 + int'($urandom % 5)) do_instr();
        kind = int'($urandom % 4);
        if (kind == 3) begin
            do_fetch(TOUT, 1'b0);
            do_term(2'b11);
        end else begin
            do_fetch(pick_wait(), 1'b1);
            c = rin();
            c.ill = (kind != 0);
            c.hlt = (kind != 1);
            c.exp = ex(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, mcnt);
            tr.push_back(c);
            do_term(kind == 0 ? 2'b01 : 2'b10);
        end
    endtask

    task automatic drive(input cyc_t c);
        start = c.start; imem_valid = c.iv; dmem_valid = c.dv;
        dec_illegal = c.ill; dec_halt = c.hlt; dec_load = c.ld;
        dec_store = c.st; dec_rd_we = c.rdwe; br_taken = c.br;
    endtask

    // entered just after a rising edge; leaves just after a rising edge in IDLE
    task automatic reset_seq(input string tag);
        cyc_t z;
        z = '0;
        #2 rst_n = 1'b0;
        #1 chk({tag, "_async"}, obs(), '0);
        @(posedge clk);
        #1 chk({tag, "_hold"}, obs(), '0);
        #2 rst_n = 1'b1;
        drive(z);
        @(negedge clk);
        chk({tag, "_idle"}, obs(), '0);
        @(posedge clk);
        #1;
    endtask

    task automatic play(input int ep, input int abort_at);
        for (int i = 0; i < tr.size(); i++) begin
            drive(tr[i]);
            if (i == abort_at) begin
                reset_seq($sformatf("ep%0d_abort", ep));
                return;
            end
            @(negedge clk);
            chk($sformatf("ep%0d_cyc%0d", ep, i), obs(), tr[i].exp);
            @(posedge clk);
            #1;
        end
        reset_seq($sformatf("ep%0d_end", ep));
    endtask

    initial begin
        int abort_at;
        cyc_t z;
        z = '0;
        drive(z);
        @(posedge clk);
        #1;
        reset_seq("init");
        for (int ep = 0; ep < 40; ep++) begin
            tr.delete();
            build();
            abort_at = -1;
            if (ep % 3 == 1) begin
                for (int i = 0; i < tr.size(); i++)
                    if (abort_at < 0 && tr[i].exp[21]) abort_at = i + int'($urandom % 2);
                if (abort_at >= 0 && !tr[abort_at].exp[21]) abort_at--;
            end
            play(ep, abort_at);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
